// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - digit-serial adder/subtractor with valid/ready handshakes
// Ripple slice processes DIGIT bits per cycle; carry is held in a register between digits.

module serial_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             msb_ci
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co     = c[DIGIT];
  // Carry into the top bit of the digit; on the last digit this is the MSB carry-in for overflow.
  assign msb_ci = c[DIGIT-1];

endmodule

module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_msb_ci;

  serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x      (a_q[DIGIT-1:0]),
    .y      (b_q[DIGIT-1:0]),
    .ci     (carry_q),
    .s      (dig_sum),
    .co     (dig_co),
    .msb_ci (dig_msb_ci)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_sum;
        carry_d = dig_co;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = dig_co;
          ovf_d   = dig_msb_ci ^ dig_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed and random checks of serial_adder_n (8/1 and 16/4)

module tb_serial_adder_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin, sub, out_ready;
  logic        in_valid8, in_valid16;

  logic        in_ready8, out_valid8, busy8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        in_ready16, out_valid16, busy16, cout16, ovf16;
  logic [15:0] sum16;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  serial_adder_n #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  task automatic txn(input bit wide, input logic [15:0] ta, input logic [15:0] tb_v,
                     input logic tcin, input logic tsub,
                     input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    a = ta; b = tb_v; cin = tcin; sub = tsub; out_ready = 1'b1;
    if (wide) in_valid16 = 1'b1; else in_valid8 = 1'b1;
    check({tag, "_in_ready"}, wide ? in_ready16 : in_ready8, 1);
    @(negedge clk);
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    check({tag, "_busy"}, wide ? busy16 : busy8, 1);
    lat = 1;
    while (!(wide ? out_valid16 : out_valid8) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, wide ? 5 : 9);
    check({tag, "_sum"}, wide ? sum16 : {8'h00, sum8}, es);
    check({tag, "_cout"}, wide ? cout16 : cout8, ec);
    check({tag, "_ovf"}, wide ? ovf16 : ovf8, eo);
    @(negedge clk);
    check({tag, "_idle"}, wide ? {in_ready16, out_valid16} : {in_ready8, out_valid8}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2 ms");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic        rc, rs, eo;
    logic [16:0] r;

    rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready8", in_ready8, 1);
    check("rst_flags8", {out_valid8, busy8, cout8, ovf8}, 4'b0000);
    check("rst_sum8", sum8, 8'h00);
    check("rst_in_ready16", in_ready16, 1);
    check("rst_flags16", {out_valid16, busy16, cout16, ovf16}, 4'b0000);
    check("rst_sum16", sum16, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    txn(0, 16'h5A, 16'h3C, 0, 0, 16'h96, 0, 1, "add_5a_3c");
    txn(0, 16'hFF, 16'h01, 0, 0, 16'h00, 1, 0, "add_ff_01");
    txn(0, 16'h00, 16'h00, 1, 0, 16'h01, 0, 0, "add_cin");
    txn(0, 16'h10, 16'h20, 0, 1, 16'hF0, 0, 0, "sub_10_20");
    txn(0, 16'h80, 16'h01, 0, 1, 16'h7F, 1, 1, "sub_80_01");
    txn(0, 16'h33, 16'h33, 1, 1, 16'h00, 1, 0, "sub_33_33");
    txn(0, 16'h7F, 16'h7F, 1, 0, 16'hFF, 0, 1, "add_7f_7f_c");

    // Backpressure in DONE while new operands are offered.
    a = 16'h5A; b = 16'h3C; cin = 1'b0; sub = 1'b0; out_ready = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = (i % 2 == 0);
      a = 16'hA0 + 16'(i); b = 16'h55;
      @(negedge clk);
      check("bp_sum", sum8, 8'h96);
      check("bp_flags", {cout8, ovf8}, 2'b01);
      check("bp_handshake", {in_ready8, out_valid8}, 2'b01);
    end
    a = 16'h01; b = 16'h02; in_valid8 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {in_ready8, out_valid8}, 2'b10);
    check("bp_release_hold", sum8, 8'h96);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("bp_new_busy", busy8, 1);
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_new_latency", lat, 9);
    check("bp_new_sum", sum8, 8'h03);
    @(negedge clk);

    // Reset while the third digit is being processed.
    a = 16'hFF; b = 16'h00; cin = 1'b0; sub = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", busy8, 1);
    check("mid_partial", sum8, 8'h03);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", {in_ready8, out_valid8, busy8}, 3'b100);
    check("mid_rst_sum", sum8, 8'h00);
    txn(0, 16'h12, 16'h34, 0, 0, 16'h46, 0, 0, "after_rst");

    txn(1, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "w16_add");
    txn(1, 16'h0000, 16'h0001, 0, 1, 16'hFFFF, 0, 0, "w16_sub");
    txn(1, 16'h8000, 16'h8000, 1, 0, 16'h0001, 1, 1, "w16_add_neg");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (rs) begin
        r  = {1'b0, ra} - {1'b0, rb};
        r[16] = (ra >= rb);
        eo = (ra[15] != rb[15]) && (r[15] != ra[15]);
      end else begin
        r  = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
        eo = (ra[15] == rb[15]) && (r[15] != ra[15]);
      end
      txn(1, ra, rb, rc, rs, r[15:0], r[16], eo, "rnd16");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised multi-cycle adder/subtractor built around a DIGIT-bit full-adder slice with a registered carry.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, LSB digit first.
- Uses valid/ready handshakes on input and output, so it can sit between datapath stages where area matters more than throughput.
- Successor to the single-bit structural full adder: generalised in width and digit size, adds a subtract mode, signed overflow and flow control.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be at least 2.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH exactly.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used in add mode only.
- sub  input  1  0 = add, 1 = subtract (A − B).
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in subtract mode 1 means no borrow.
- ovf  output  1  signed overflow.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - in_ready=1; out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0.
  - Digit counter and carry register cleared.
  - Reset wins over every other input in the same cycle, including mid-RUN or in DONE; any in-flight result is discarded.
- FSM states: IDLE, RUN, DONE. Let N = WIDTH/DIGIT.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready at edge T, capture the operand set and go to RUN:
    - a → A shift register.
    - b XOR {WIDTH{sub}} → B shift register.
    - carry register ← sub ? 1 : cin.
    - digit counter ← 0; sum cleared.
  - Inputs are ignored in every other state.
- RUN (edges T+1 … T+N):
  - Each edge adds the low DIGIT bits of A and B plus the carry register.
  - The DIGIT-bit result is written into sum at digit position k; the carry register takes the digit carry-out.
  - A and B shift right by DIGIT; counter increments.
  - At the last digit (k=N−1):
    - cout ← final carry.
    - ovf ← carry into the MSB XOR carry out of the MSB. The slice exposes the MSB carry-in for this.
    - Go to DONE.
- DONE (from T+N+1):
  - out_valid=1; sum, cout and ovf held stable.
  - in_ready=0 until the result is taken.
  - On out_valid && out_ready, go to IDLE; in_ready=1 on the following cycle.
  - Outputs keep their last value after the handshake until the next capture clears sum.
- Latency: out_valid rises exactly N+1 cycles after the accepting edge.
  - Minimum initiation interval is N+2 cycles when out_ready is held high.
- Arithmetic:
  - Add mode: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
  - Subtract mode: sum = a − b mod 2^WIDTH; cout = (a ≥ b unsigned); cin ignored.
  - ovf follows two's-complement rules for both modes.
- Boundary rules:
  - Wrap-around is modular with no saturation.
  - in_valid asserted during RUN or DONE is not accepted and produces no side effect.
  - The source must hold its operands until the handshake.
  - out_ready asserted outside DONE has no effect.
  - in_valid and out_ready both high in DONE: only the output handshake completes that cycle.

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A b=0x3C cin=0, out_ready=1 → out_valid exactly 9 cycles after accept; sum=0x96, cout=0, ovf=1.
- Add a=0xFF b=0x01 cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x00 b=0x00 cin=1 → sum=0x01, cout=0, ovf=0.
- Subtract:
  - a=0x10 b=0x20 → sum=0xF0, cout=0, ovf=0.
  - a=0x80 b=0x01 → sum=0x7F, cout=1, ovf=1.
  - a=0x33 b=0x33 with cin=1 → sum=0x00, cout=1 (cin ignored).
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid with new operands → sum, cout, ovf stable, in_ready=0, no new capture. Release out_ready → IDLE next cycle, then the new operands are accepted.
- Reset mid-operation: assert rst at RUN digit 3 → next cycle state IDLE, in_ready=1, out_valid=0, sum=0. A following transaction completes correctly.
- WIDTH=16, DIGIT=4: a=0xFFFF b=0x0001 cin=0 → out_valid 5 cycles after accept, sum=0x0000, cout=1, ovf=0. Also run 1000 random back-to-back transactions in both modes against a reference model.
